// File: rtl/ps2_pkg.sv
// Shared types, protocol constants and scan-code lookup for the PS/2 keyboard front end.
// Optional parity checking in ps2_rx is enabled by defining PS2_PARITY_CHECK_EN.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      EXT,
      BREAK,
      EXT_BREAK
   } ps2_state_e;

   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;

   // Set-2 scan code to lower-case ASCII; letters, digits and space only.
   function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
      logic [7:0] a;
      case (code)
         8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
         8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
         8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
         8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
         8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
         8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
         8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
         8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
         8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
         8'h3E: a = 8'h38; 8'h46: a = 8'h39;
         8'h29: a = 8'h20;
         default: a = 8'h00;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronisers, falling-edge detect, 11-bit framing, idle timeout.
// Defining PS2_PARITY_CHECK_EN rejects frames with even parity over D0..D7 plus parity.
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_err
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

   logic [2:0]    clk_sync_q, clk_sync_d;
   logic [2:0]    data_sync_q, data_sync_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [8:0]    shift_q, shift_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    byte_q, byte_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;
   logic          fall, bit_in, par_ok;
`ifdef PS2_PARITY_CHECK_EN
   logic          par_q, par_d;
`endif

   always_comb begin
      clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
      data_sync_d = {data_sync_q[1:0], ps2_data};
      fall        = clk_sync_q[2] & ~clk_sync_q[1];
      bit_in      = data_sync_q[1];
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      byte_d      = byte_q;
      valid_d     = 1'b0;
      err_d       = 1'b0;
      tmo_d       = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TW'(1);
`ifdef PS2_PARITY_CHECK_EN
      par_d       = par_q;
      par_ok      = ^{shift_q[8:1], par_q};
`else
      par_ok      = 1'b1;
`endif
      if (fall) begin
         tmo_d = '0;
         if (bit_cnt_q == 4'd10) begin
            // shift_q[0] is the start bit, shift_q[8:1] is D0..D7; bit_in is the stop bit
            bit_cnt_d = '0;
            if (!shift_q[0] && bit_in && par_ok) begin
               valid_d = 1'b1;
               byte_d  = shift_q[8:1];
            end else begin
               err_d = 1'b1;
            end
         end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd9) begin
`ifdef PS2_PARITY_CHECK_EN
               par_d = bit_in;
`endif
            end else begin
               shift_d = {bit_in, shift_q[8:1]};
            end
         end
      end else if (tmo_q == TMO_MAX && bit_cnt_q != '0) begin
         bit_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_q  <= '0;
         data_sync_q <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         tmo_q       <= '0;
         byte_q      <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         par_q       <= 1'b0;
`endif
      end else begin
         clk_sync_q  <= clk_sync_d;
         data_sync_q <= data_sync_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         tmo_q       <= tmo_d;
         byte_q      <= byte_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
`ifdef PS2_PARITY_CHECK_EN
         par_q       <= par_d;
`endif
      end
   end

   assign rx_byte  = byte_q;
   assign rx_valid = valid_q;
   assign rx_err   = err_q;

endmodule

// File: rtl/ps2_key_fsm.sv
// PS/2 keyboard front end: make/break/extended decode feeding data/ascii/counts displays.
// PS2_PARITY_CHECK_EN (see ps2_rx) enables parity rejection of received frames.
module ps2_key_fsm
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] data,
   output logic [7:0] ascii,
   output logic [7:0] counts,
   output logic       key_valid,
   output logic       frame_err
);

   logic [7:0] rx_byte;
   logic       rx_valid, rx_err;

   ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .rx_err   (rx_err)
   );

   ps2_state_e state_q, state_d;
   logic [7:0] data_q, data_d, ascii_q, ascii_d, counts_q, counts_d;
   logic       key_valid_q, key_valid_d, frame_err_q, frame_err_d;
   logic       is_make, is_rel;
   logic [7:0] make_ascii;

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      ascii_d     = ascii_q;
      counts_d    = counts_q;
      key_valid_d = key_valid_q;
      frame_err_d = rx_err;
      is_make     = 1'b0;
      is_rel      = 1'b0;
      make_ascii  = 8'h00;
      if (rx_valid) begin
         case (state_q)
            IDLE: begin
               if (rx_byte == PS2_BREAK)    state_d = BREAK;
               else if (rx_byte == PS2_EXT) state_d = EXT;
               else begin
                  is_make    = 1'b1;
                  make_ascii = scan_to_ascii(rx_byte);
               end
            end
            EXT: begin
               if (rx_byte == PS2_BREAK) state_d = EXT_BREAK;
               else begin
                  is_make = 1'b1;
                  state_d = IDLE;
               end
            end
            default: begin
               is_rel  = 1'b1;
               state_d = IDLE;
            end
         endcase
      end
      // Same code while held is typematic repeat and leaves everything untouched
      if (is_make && (!key_valid_q || rx_byte != data_q)) begin
         data_d      = rx_byte;
         ascii_d     = make_ascii;
         counts_d    = counts_q + 8'd1;
         key_valid_d = 1'b1;
      end
      if (is_rel && rx_byte == data_q) key_valid_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         data_q      <= '0;
         ascii_q     <= '0;
         counts_q    <= '0;
         key_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         ascii_q     <= ascii_d;
         counts_q    <= counts_d;
         key_valid_q <= key_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign data      = data_q;
   assign ascii     = ascii_q;
   assign counts    = counts_q;
   assign key_valid = key_valid_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_fsm.sv
// Self-checking bench for ps2_key_fsm: bit-banged PS/2 frames, reference model and scoreboard.
module tb_ps2_key_fsm;

   localparam int unsigned TMO = 200;

   logic       clk = 1'b0;
   logic       rst, ps2_clk, ps2_data;
   logic [7:0] data, ascii, counts;
   logic       key_valid, frame_err;

   ps2_key_fsm #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .data      (data),
      .ascii     (ascii),
      .counts    (counts),
      .key_valid (key_valid),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic [7:0] ascii;
      logic [7:0] counts;
      logic       key_valid;
      logic       frame_err;
   } obs_t;

   obs_t exp_q[$];
   obs_t mdl;
   int   mst;
   int   vectors = 0;
   int   miscompares = 0;

   function automatic obs_t sample();
      return {data, ascii, counts, key_valid, frame_err};
   endfunction

   task automatic check(input string tag, input obs_t exp);
      obs_t got;
      got = sample();
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: got %h expected %h (data,ascii,counts,kv,err)", tag, got, exp);
      end
   endtask

   task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ref_ascii(input logic [7:0] c);
      case (c)
         8'h1C: return 8'h61;
         8'h32: return 8'h62;
         8'h45: return 8'h30;
         8'h16: return 8'h31;
         8'h29: return 8'h20;
         default: return 8'h00;
      endcase
   endfunction

   // mst: 0 idle, 1 after E0, 2 after F0, 3 after E0 F0
   task automatic model_byte(input logic [7:0] b);
      bit mk = 0, rel = 0;
      logic [7:0] a = 8'h00;
      if (mst == 0) begin
         if (b == 8'hF0) mst = 2;
         else if (b == 8'hE0) mst = 1;
         else begin mk = 1; a = ref_ascii(b); end
      end else if (mst == 1) begin
         if (b == 8'hF0) mst = 3;
         else begin mk = 1; mst = 0; end
      end else begin
         rel = 1; mst = 0;
      end
      if (mk && (!mdl.key_valid || b != mdl.data)) begin
         mdl.data = b; mdl.ascii = a; mdl.counts = mdl.counts + 8'd1; mdl.key_valid = 1'b1;
      end
      if (rel && b == mdl.data) mdl.key_valid = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
      logic [10:0] f;
      obs_t prev, e;
      bit perr;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
`ifdef PS2_PARITY_CHECK_EN
      perr = bad_par;
`else
      perr = 1'b0;
`endif
      prev = mdl;
      if (nbits == 11) begin
         if (bad_stop || perr) begin
            e = mdl; e.frame_err = 1'b1;
         end else begin
            model_byte(b); e = mdl;
         end
         exp_q.push_back(e);
      end
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         repeat (5) @(negedge clk);
         ps2_clk = 1'b0;
         if (i == 10) begin
            repeat (3) @(posedge clk);
            #1 check("before_update", prev);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
               vectors++; miscompares++;
               $error("FAIL scoreboard: got empty queue expected an entry");
            end else begin
               e = exp_q.pop_front();
               check("frame_result", e);
            end
            @(posedge clk);
            #1 e.frame_err = 1'b0;
            check("err_one_cycle", e);
            @(negedge clk);
         end else begin
            repeat (5) @(negedge clk);
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      mdl = '0;
      mst = 0;
      repeat (5) @(negedge clk);
      check("after_reset", '0);
   endtask

   initial begin
      rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
      mdl = '0; mst = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("reset_state", '0);

      send(8'h1C, 0, 0, 11);
      check8("a_data", data, 8'h1C);
      check8("a_ascii", ascii, 8'h61);
      check8("a_counts", counts, 8'h01);
      check8("a_valid", {7'd0, key_valid}, 8'h01);

      repeat (3) send(8'h1C, 0, 0, 11);
      send(8'hF0, 0, 0, 11);
      send(8'h1C, 0, 0, 11);
      check8("typematic_counts", counts, 8'h01);
      check8("release_valid", {7'd0, key_valid}, 8'h00);
      check8("release_data", data, 8'h1C);

      send(8'hE0, 0, 0, 11);
      send(8'h75, 0, 0, 11);
      check8("ext_data", data, 8'h75);
      check8("ext_ascii", ascii, 8'h00);
      check8("ext_counts", counts, 8'h02);
      send(8'hE0, 0, 0, 11);
      send(8'hF0, 0, 0, 11);
      send(8'h75, 0, 0, 11);
      check8("ext_release", {7'd0, key_valid}, 8'h00);
      send(8'h1C, 0, 0, 11);
      check8("idle_after_ext_ascii", ascii, 8'h61);
      check8("idle_after_ext_counts", counts, 8'h03);

      send(8'h16, 1, 0, 11);
`ifdef PS2_PARITY_CHECK_EN
      check8("badpar_data", data, 8'h1C);
`else
      check8("badpar_data", data, 8'h16);
      check8("badpar_ascii", ascii, 8'h31);
`endif

      do_reset();
      for (int n = 0; n < 256; n++) begin
         send(8'h45, 0, 0, 11);
         send(8'hF0, 0, 0, 11);
         send(8'h45, 0, 0, 11);
      end
      check8("wrap_counts", counts, 8'h00);
      check8("wrap_data", data, 8'h45);

      send(8'h45, 0, 1, 11);
      check8("badstop_counts", counts, 8'h00);

      send(8'h00, 0, 0, 5);
      repeat (TMO + 50) @(negedge clk);
      check("timeout_quiet", mdl);
      send(8'h32, 0, 0, 11);
      check8("timeout_data", data, 8'h32);
      check8("timeout_ascii", ascii, 8'h62);

      send(8'h55, 0, 0, 5);
      do_reset();
      send(8'h32, 0, 0, 11);
      check8("post_rst_data", data, 8'h32);
      check8("post_rst_counts", counts, 8'h01);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ps2_key_fsm.md
# ps2_key_fsm

Keyboard front end of the PS/2 display path. Receives raw PS/2 frames from the keyboard pins, decodes make/break/extended scan-code sequences, and presents the currently pressed key's scan code, its ASCII code and a running key-press count. These three bytes feed the seven-segment decoder directly, two digits each.

## Interface
Parameters:
- TIMEOUT_CYCLES, 50000: idle `clk` cycles without a PS/2 falling edge before a partial frame is discarded.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw keyboard clock, asynchronous.
- ps2_data  in  1  raw keyboard data, asynchronous.
- data  out  8  scan code of the last key pressed; reset 0x00.
- ascii  out  8  ASCII of `data`; 0x00 if unmapped or extended; reset 0x00.
- counts  out  8  number of distinct presses, mod 256; reset 0x00.
- key_valid  out  1  a key is currently held; reset 0.
- frame_err  out  1  one-cycle pulse per discarded frame; reset 0.

## Operation
- **Synchronisation:** `ps2_clk` and `ps2_data` each pass through a 3-flop synchroniser. Falling edge `fall` = previous sync bit 1 and current 0.
- **Frame format:** 11 bits sampled on `fall`: start(0), D0..D7 (LSB first), odd parity, stop(1). A 4-bit bit counter runs 0..10.
- **Frame checks:**
  - Start bit must be 0 and stop bit must be 1, otherwise the frame is dropped and `frame_err` pulses.
  - Parity is handled per Configuration.
- **Timeout:** A counter clears on every `fall` and saturates. When it reaches TIMEOUT_CYCLES with the bit counter non-zero, the bit counter clears. No `frame_err` pulse is generated for a timeout.
- **Decode FSM states:**
  - IDLE: byte 0xF0 goes to BREAK, byte 0xE0 goes to EXT, any other byte is a make code.
  - EXT: byte 0xF0 goes to EXT_BREAK; any other byte is a make code with `ascii` forced to 0x00, then back to IDLE.
  - BREAK / EXT_BREAK: the next byte is a release, then back to IDLE.
- **Make code:**
  - If `key_valid`=0 or the byte differs from `data`: `data` takes the byte, `ascii` takes the lookup value, `counts` increments (wrapping 0xFF to 0x00), and `key_valid` is set to 1.
  - If the byte equals `data` while `key_valid`=1, it is typematic repeat and nothing changes.
- **Release:**
  - If the byte equals `data`, `key_valid` goes to 0.
  - `data`, `ascii` and `counts` hold their values.
  - A release of any other code is ignored.
- **ASCII map:** 0x1C→0x61 'a', 0x32→0x62 'b', through z; 0x45→0x30 '0', 0x16→0x31 '1', through 9; 0x29→0x20 space. All other codes map to 0x00.
- **Reset:** `rst` mid-frame clears the bit counter, the FSM (to IDLE), all outputs and the synchronisers. Bits received before reset are lost.

## Timing
- Input to `fall`: 3 `clk` cycles of synchroniser latency.
- Receiver registers the byte and raises internal `rx_valid` on the cycle after the `fall` that samples the stop bit.
- FSM updates outputs on the edge where `rx_valid`=1. Outputs are therefore visible 2 cycles after the stop-bit `fall` cycle.
- `frame_err` is visible at the same point as a valid byte would have been.
- The PS/2 clock (10–16.7 kHz) is required to be more than 8× slower than `clk`. Back-to-back frames need no handshake; `rx_valid` is a single-cycle pulse.

## Configuration
- `PS2_PARITY_CHECK_EN`:
  - Defined: a frame whose D0..D7 plus parity has an even number of ones is dropped, `frame_err` pulses, and FSM state is unchanged.
  - Undefined: the parity bit is sampled and ignored, and only start/stop errors raise `frame_err`.

## Structure
- Package `ps2_pkg` holds:
  - the FSM state enum (IDLE, EXT, BREAK, EXT_BREAK);
  - constants PS2_BREAK=0xF0 and PS2_EXT=0xE0;
  - the scan-to-ASCII lookup function.
- Sub-module `ps2_rx` holds the synchroniser, edge detect, bit counter, timeout and frame checks. It outputs `rx_byte[7:0]`, `rx_valid` and `rx_err`.
- `ps2_key_fsm` instantiates `ps2_rx` and contains the decode FSM and output registers.

## Test plan
- Frame 0x1C after reset → `data`=0x1C, `ascii`=0x61, `counts`=0x01, `key_valid`=1, two cycles after the stop-bit `fall`.
- Frame 0x1C repeated 3 times, then 0xF0 0x1C → `counts` stays 0x01; `key_valid`=0; `data`=0x1C retained.
- Sequence 0xE0 0x75 → `data`=0x75, `ascii`=0x00, `counts` incremented. Then 0xE0 0xF0 0x75 → `key_valid`=0, FSM returns to IDLE.
- Frame 0x16 with bad parity:
  - `PS2_PARITY_CHECK_EN` defined → `frame_err` pulses once, outputs unchanged.
  - Undefined → `data`=0x16, `ascii`=0x31.
- 256 press/release pairs of 0x45 → `counts` wraps to 0x00. Stop bit driven 0 → `frame_err` pulse, no output change.
- 5 bits sent, then idle for more than TIMEOUT_CYCLES, then a full 0x32 frame → `data`=0x32 and no `frame_err`. Repeat with `rst` asserted mid-frame → all outputs 0x00/0, then the next frame decodes normally.
